// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction memory write bus and status out
interface program_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [15:0] load_address;
    logic        load_instruction;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, instruction_in, load_address, load_instruction,
               cpu_reset, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, instruction_in, load_address, load_instruction,
               cpu_reset, done, error
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a count-prefixed byte stream into instruction memory
module program_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              pc_reset_n,
    program_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_remaining;
    logic [15:0] r_instruction;
    logic [15:0] r_load_address;
    logic        r_load_instruction;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic [15:0] w_count_full;

    assign w_accept     = bus.byte_valid & bus.byte_ready;
    // The full count as it will stand once the low byte lands this cycle.
    assign w_count_full = {r_count[15:8], bus.byte_in};

    // Ready is the only output decoded straight from state.
    always_comb begin
        bus.byte_ready = 1'b0;
        case (r_state)
            S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO: bus.byte_ready = 1'b1;
            default:                                  bus.byte_ready = 1'b0;
        endcase
    end

    assign bus.instruction_in   = r_instruction;
    assign bus.load_address     = r_load_address;
    assign bus.load_instruction = r_load_instruction;
    assign bus.cpu_reset        = r_cpu_reset;
    assign bus.done             = r_done;
    assign bus.error            = r_error;

    // Loader FSM with all outputs registered; the strobe is set on entry to WRITE.
    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_state            <= S_IDLE;
            r_count            <= 16'd0;
            r_remaining        <= 16'd0;
            r_instruction      <= 16'd0;
            r_load_address     <= 16'd0;
            r_load_instruction <= 1'b0;
            r_cpu_reset        <= 1'b1;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        r_state        <= S_CNT_HI;
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                        r_load_address <= 16'd0;
                        r_cpu_reset    <= 1'b1;
                    end
                end
                S_CNT_HI: begin
                    if (w_accept) begin
                        r_count <= {bus.byte_in, r_count[7:0]};
                        r_state <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_count <= w_count_full;
                        if (w_count_full == 16'd0) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else if ({1'b0, w_count_full} > LP_MAX) begin
                            r_state     <= S_ERROR;
                            r_error     <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_remaining <= w_count_full;
                            r_state     <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_instruction[15:8] <= bus.byte_in;
                        r_state             <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        r_instruction[7:0] <= bus.byte_in;
                        r_load_instruction <= 1'b1;
                        r_state            <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_load_instruction <= 1'b0;
                    r_load_address     <= r_load_address + 16'd1;
                    r_remaining        <= r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state <= S_DATA_HI;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic mon_en;
    logic prev_strobe;

    logic [31:0] exp_q[$];
    logic [7:0]  stream[$];

    program_loader_if bus();

    program_loader #(.MAX_WORDS(256)) dut (
        .clk        (clk),
        .pc_reset_n (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.load_instruction) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    chk("wr_addr", {16'd0, bus.load_address}, {16'd0, w[31:16]});
                    chk("wr_data", {16'd0, bus.instruction_in}, {16'd0, w[15:0]});
                end
                chk("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
            end
            chk("cpu_reset_vs_done", {31'd0, bus.cpu_reset}, {31'd0, ~bus.done});
            chk("done_error_exclusive", {31'd0, bus.done & bus.error}, 32'd0);
            prev_strobe = bus.load_instruction;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    // Reference model: derive the writes and final status straight from the stream.
    task automatic model(output int n, output int is_err);
        n = int'(stream[0]) * 256 + int'(stream[1]);
        is_err = (n > 256) ? 1 : 0;
        if (!is_err) begin
            for (int i = 0; i < n; i++) begin
                logic [15:0] word;
                logic [15:0] addr;
                word = {stream[2 + 2*i], stream[3 + 2*i]};
                addr = 16'(i);
                exp_q.push_back({addr, word});
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_done_clr",  {31'd0, bus.done},       32'd0);
        chk("start_error_clr", {31'd0, bus.error},      32'd0);
        chk("start_cpu_reset", {31'd0, bus.cpu_reset},  32'd1);
        chk("start_addr",      {16'd0, bus.load_address}, 32'd0);
        chk("start_ready",     {31'd0, bus.byte_ready}, 32'd1);
    endtask

    task automatic send_bytes(input int gap_pct);
        for (int i = 0; i < stream.size(); i++) begin
            logic acc;
            int   guard;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                bus.byte_valid = ($urandom_range(0, 99) >= gap_pct);
                bus.byte_in    = bus.byte_valid ? stream[i] : 8'($urandom);
                bus.start      = (gap_pct > 0) && ($urandom_range(0, 3) == 0);
                acc = bus.byte_valid && bus.byte_ready;
                guard++;
            end
            if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
    endtask

    task automatic finish_check(input int n, input int is_err);
        int k;
        k = 0;
        while (!(bus.done || bus.error) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("end_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        chk("end_done",      {31'd0, bus.done},       is_err ? 32'd0 : 32'd1);
        chk("end_error",     {31'd0, bus.error},      is_err ? 32'd1 : 32'd0);
        chk("end_cpu_reset", {31'd0, bus.cpu_reset},  is_err ? 32'd1 : 32'd0);
        chk("end_ready",     {31'd0, bus.byte_ready}, 32'd0);
        chk("end_all_writes", exp_q.size(), 32'd0);
        chk("end_addr", {16'd0, bus.load_address}, is_err ? 32'd0 : 32'(16'(n)));
    endtask

    task automatic run_load(input int gap_pct);
        int n;
        int e;
        model(n, e);
        do_start();
        send_bytes(gap_pct);
        finish_check(n, e);
    endtask

    task automatic set_stream4(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        stream = {};
        stream.push_back(a);
        stream.push_back(b);
        stream.push_back(c);
        stream.push_back(d);
    endtask

    initial begin
        int n;
        int e;
        total = 0;
        bad = 0;
        mon_en = 1'b0;
        prev_strobe = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.byte_in = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cpu_reset", {31'd0, bus.cpu_reset},        32'd1);
        chk("rst_done",      {31'd0, bus.done},             32'd0);
        chk("rst_error",     {31'd0, bus.error},            32'd0);
        chk("rst_strobe",    {31'd0, bus.load_instruction}, 32'd0);
        chk("rst_ready",     {31'd0, bus.byte_ready},       32'd0);
        chk("rst_addr",      {16'd0, bus.load_address},     32'd0);
        chk("rst_instr",     {16'd0, bus.instruction_in},   32'd0);
        mon_en = 1'b1;

        // Nominal load with valid held; model pinned to hand-computed writes.
        stream = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        model(n, e);
        chk("model_nom_n",  32'(n), 32'd2);
        chk("model_nom_w0", exp_q[0], 32'h0000_1234);
        chk("model_nom_w1", exp_q[1], 32'h0001_ABCD);
        exp_q = {};
        run_load(0);

        // Same stream with random gaps and stray start pulses.
        run_load(50);

        // Reload from DONE.
        set_stream4(8'h00, 8'h01, 8'h55, 8'hAA);
        model(n, e);
        chk("model_reload_w0", exp_q[0], 32'h0000_55AA);
        exp_q = {};
        run_load(30);

        // Zero count.
        stream = {8'h00, 8'h00};
        run_load(0);

        // Oversize count, then the largest accepted count.
        stream = {8'h01, 8'h01};
        model(n, e);
        chk("model_over_err", 32'(e), 32'd1);
        exp_q = {};
        run_load(20);

        stream = {8'h01, 8'h00};
        for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
        run_load(0);

        // Randomized loads, including random oversize counts.
        for (int t = 0; t < 10; t++) begin
            int nn;
            nn = (t == 9) ? int'($urandom_range(257, 2000)) : int'($urandom_range(1, 6));
            stream = {8'(nn >> 8), 8'(nn)};
            if (nn <= 256)
                for (int i = 0; i < 2 * nn; i++) stream.push_back(8'($urandom));
            run_load(int'($urandom_range(0, 60)));
        end

        // Reset in the middle of a word: no strobe, immediate IDLE values.
        stream = {8'h00, 8'h02, 8'h12};
        do_start();
        send_bytes(0);
        exp_q = {};
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cpu_reset", {31'd0, bus.cpu_reset},        32'd1);
        chk("midrst_addr",      {16'd0, bus.load_address},     32'd0);
        chk("midrst_ready",     {31'd0, bus.byte_ready},       32'd0);
        chk("midrst_strobe",    {31'd0, bus.load_instruction}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h34;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("postrst_idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        chk("postrst_cpu_reset",  {31'd0, bus.cpu_reset},  32'd1);
        chk("postrst_done",       {31'd0, bus.done},       32'd0);

        // A clean load still works after the abort.
        set_stream4(8'h00, 8'h01, 8'hBE, 8'hEF);
        run_load(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
